// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: FSM encodings and counter sizing shared by the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_sub_fs_cell.sv
// fs_cell: one-bit combinational full subtractor, d = a - b - bin.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned a - b, LSB first, WIDTH cycles per result.
// Define SERIAL_SUB_SAT_EN to clamp underflowing results to zero.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d, res;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d, borrow_q, borrow_d;
    logic             d, bout, last, accept;

    fs_cell u_fs (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .bin (bin_q),
        .d   (d),
        .bout(bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        last    = cnt_q == CW'(WIDTH - 1);
        state_d = (state_q == IDLE)  ? (start ? SHIFT : IDLE) :
                  (state_q == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    end

    always_comb begin
        accept = state_q == IDLE && start;
        res    = {d, r_q[WIDTH-1:1]};
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        if (accept) begin
            a_d   = a;
            b_d   = b;
            cnt_d = '0;
            bin_d = 1'b0;
        end else if (state_q == SHIFT) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            r_d   = res;
            bin_d = bout;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
`ifdef SERIAL_SUB_SAT_EN
                diff_d = bout ? '0 : res;
`else
                diff_d = res;
`endif
                borrow_d = bout;
            end
        end
    end

    always_comb begin
        busy   = state_q == SHIFT;
        done   = state_q == DONE;
        diff   = diff_q;
        borrow = borrow_q;
    end
endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial unsigned subtractor: computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the inverse-direction counterpart to the team's combinational adder cells. It serves area-constrained datapaths that can accept WIDTH-cycle latency in exchange for one arithmetic cell. Requests use a start/busy/done handshake toward a controlling FSM.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 2 or more.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request pulse; sampled only in IDLE.
- `a` input WIDTH: minuend; captured on the edge where start is accepted.
- `b` input WIDTH: subtrahend; captured on the same edge as `a`.
- `busy` output 1: high while in SHIFT.
- `done` output 1: high for exactly one cycle when the result becomes valid.
- `diff` output WIDTH: result, registered; holds its value until the next result.
- `borrow` output 1: final borrow out; 1 means a < b.

## Operation
- Reset (async): state goes to IDLE; `busy`, `done` and `borrow` go to 0; `diff` goes to 0; shift registers, bit counter and internal borrow are cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE with start=1: capture `a` and `b` into shift registers, clear the internal borrow, set count=0, go to SHIFT.
  - IDLE with start=0: stay in IDLE.
  - SHIFT, each cycle:
    - Apply the cell to the LSBs: d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
    - Shift the operand registers right by one.
    - Shift d into the MSB of the result register.
    - Register bout as the next bin; increment count.
  - SHIFT with count==WIDTH-1: after processing this last bit, go to DONE and load `diff` and `borrow` from the result register and final bout.
  - DONE: `done`=1 for one cycle, then unconditionally go to IDLE.
- `start` is ignored in SHIFT and DONE; there is no queuing. A request is accepted only in IDLE.
- `diff` and `borrow` change only on DONE entry. Between operations they hold the last result.
- Arithmetic is unsigned modulo 2^WIDTH. `borrow` equals the borrow out of the MSB.
- `a` and `b` may change freely after the capture edge.

## Timing
- Let E0 be the edge where start is accepted.
- Edges E0+1 through E0+WIDTH each process one bit.
- At edge E0+WIDTH the FSM enters DONE: `done`, `diff` and `borrow` update and are visible in the following cycle.
- `busy` is high from after E0 until edge E0+WIDTH.
- `done` falls at E0+WIDTH+1.
- Minimum start-to-start spacing is WIDTH+2 edges; the earliest new accept is at E0+WIDTH+2, with start held or re-asserted.
- Reset mid-operation aborts immediately. No `done` is produced, and the outputs show reset values.
- All outputs are driven from registers; there is no combinational input-to-output path.

## Configuration
- Macro `SERIAL_SUB_SAT_EN`.
- Defined: on underflow (final borrow=1), `diff` is loaded with 0 instead of the wrapped value; `borrow` still reports 1.
- Undefined: `diff` is the two's-complement wrapped result.
- Latency is identical in both builds.

## Structure
- Shared package `serial_sub_pkg`:
  - FSM state typedef/encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Counter-width constant derived as $clog2(WIDTH).
- Sub-module `fs_cell`: combinational full-subtractor with inputs a, b, bin and outputs d, bout. It is the exact dual of the team's half/full-adder cells and is instantiated once.
- Top level holds the FSM, counter, shift registers, borrow flop and output registers.

## Test plan
All scenarios use WIDTH=8.
- Normal subtract: start with a=0x35, b=0x12 → `busy` high for 8 cycles; `done` pulses once at E0+8; diff=0x23, borrow=0.
- Underflow: a=0x00, b=0x01 → diff=0xFF, borrow=1. With `SERIAL_SUB_SAT_EN`: diff=0x00, borrow=1.
- Equal and extreme operands:
  - a=0xAA, b=0xAA → diff=0x00, borrow=0.
  - a=0xFF, b=0x00 → diff=0xFF, borrow=0.
- Start while busy: start pulses at E0+3 with different operands → ignored; result is still that of the first operands; only one `done`.
- Reset mid-operation: assert rst at E0+4 → outputs go to 0 asynchronously; no `done`; the next start computes correctly (0x10-0x01 → 0x0F).
- Back-to-back: hold start high continuously with a=0x80, b=0x7F → accepts every 10 edges; each result is diff=0x01, borrow=0; `done` pulses are spaced 10 cycles apart.
